// File: rtl/conv3x3_s2_sched_pkg.sv
// Shared definitions for the 3x3 stride-2 convolution frame scheduler:
// state encodings, default geometry and output-map size helper.
package conv3x3_s2_sched_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StStream = 2'd1,
      StDone   = 2'd2
   } sched_state_e;

   localparam int unsigned DEF_IMG_W  = 100;
   localparam int unsigned DEF_IMG_H  = 100;
   localparam int unsigned DEF_K      = 3;
   localparam int unsigned DEF_STRIDE = 2;
   localparam int unsigned DEF_CNT_W  = 15;

   // Number of stride-aligned windows that fit along one axis.
   function automatic int unsigned out_dim(input int unsigned img, input int unsigned k,
                                           input int unsigned stride);
      return (img - k) / stride + 1;
   endfunction

   localparam int unsigned DEF_OUT_W = out_dim(DEF_IMG_W, DEF_K, DEF_STRIDE);
   localparam int unsigned DEF_OUT_H = out_dim(DEF_IMG_H, DEF_K, DEF_STRIDE);

endpackage

// File: rtl/conv3x3_s2_sched_axis_cnt.sv
// Single-axis position counter with stride phase and output index tracking.
// hit/idx describe the current position; no divider is used.
module conv_axis_cnt #(
   parameter int unsigned LEN    = 100,
   parameter int unsigned K      = 3,
   parameter int unsigned STRIDE = 2,
   parameter int unsigned CNT_W  = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] idx,
   output logic             last,
   output logic             hit
);

   logic [CNT_W-1:0] pos;
   logic [CNT_W-1:0] phase;

   assign last = (pos == CNT_W'(LEN - 1));
   assign hit  = (pos >= CNT_W'(K - 1)) && (phase == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos   <= '0;
         phase <= '0;
         idx   <= '0;
      end else if (clr) begin
         pos   <= '0;
         phase <= '0;
         idx   <= '0;
      end else if (en) begin
         if (last) begin
            pos   <= '0;
            phase <= '0;
            idx   <= '0;
         end else begin
            pos <= pos + CNT_W'(1);
            // Phase and index stay at zero until the first full window position.
            if (pos + CNT_W'(1) == CNT_W'(K - 1)) begin
               phase <= '0;
               idx   <= '0;
            end else if (pos >= CNT_W'(K - 1)) begin
               if (phase == CNT_W'(STRIDE - 1)) begin
                  phase <= '0;
                  idx   <= idx + CNT_W'(1);
               end else begin
                  phase <= phase + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/conv3x3_s2_sched.sv
// Frame scheduler for the 3x3 stride-2 conv unit: tracks raster position and
// flags stride-aligned windows. Optional CONV_SCHED_STAT_EN adds stall/window counters.
module conv3x3_s2_sched
   import conv3x3_s2_sched_pkg::*;
#(
   parameter int unsigned IMG_W  = DEF_IMG_W,
   parameter int unsigned IMG_H  = DEF_IMG_H,
   parameter int unsigned K      = DEF_K,
   parameter int unsigned STRIDE = DEF_STRIDE,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic             Pix_Valid,
   output logic             Pix_Ready,
   output logic             Busy,
   output logic             Line_Shift,
   output logic             Out_Valid,
   output logic [CNT_W-1:0] Out_Row,
   output logic [CNT_W-1:0] Out_Col,
   output logic             Done
`ifdef CONV_SCHED_STAT_EN
   ,
   output logic [CNT_W-1:0] Stall_Cnt,
   output logic [CNT_W-1:0] Win_Cnt
`endif
);

   sched_state_e     state;
   logic             accept;
   logic             clr;
   logic             win;
   logic             col_last, col_hit;
   logic             row_last, row_hit;
   logic [CNT_W-1:0] col_idx, row_idx;

   assign accept = Pix_Valid & Pix_Ready;
   assign clr    = (state == StIdle) & Start;
   assign win    = accept & col_hit & row_hit;

   conv_axis_cnt #(
      .LEN    (IMG_W),
      .K      (K),
      .STRIDE (STRIDE),
      .CNT_W  (CNT_W)
   ) u_col (
      .clk   (Clk),
      .rst_n (Rst),
      .clr   (clr),
      .en    (accept),
      .idx   (col_idx),
      .last  (col_last),
      .hit   (col_hit)
   );

   conv_axis_cnt #(
      .LEN    (IMG_H),
      .K      (K),
      .STRIDE (STRIDE),
      .CNT_W  (CNT_W)
   ) u_row (
      .clk   (Clk),
      .rst_n (Rst),
      .clr   (clr),
      .en    (accept & col_last),
      .idx   (row_idx),
      .last  (row_last),
      .hit   (row_hit)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= StIdle;
         Pix_Ready  <= 1'b0;
         Busy       <= 1'b0;
         Line_Shift <= 1'b0;
         Out_Valid  <= 1'b0;
         Out_Row    <= '0;
         Out_Col    <= '0;
         Done       <= 1'b0;
      end else begin
         Line_Shift <= accept & col_last;
         Out_Valid  <= win;
         Done       <= 1'b0;
         if (win) begin
            Out_Row <= row_idx;
            Out_Col <= col_idx;
         end
         case (state)
            StIdle: begin
               if (Start) begin
                  state     <= StStream;
                  Pix_Ready <= 1'b1;
                  Busy      <= 1'b1;
               end
            end
            StStream: begin
               if (accept && row_last && col_last) begin
                  state     <= StDone;
                  Pix_Ready <= 1'b0;
               end
            end
            StDone: begin
               state <= StIdle;
               Busy  <= 1'b0;
               Done  <= 1'b1;
            end
            default: begin
               state     <= StIdle;
               Pix_Ready <= 1'b0;
               Busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef CONV_SCHED_STAT_EN
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         Stall_Cnt <= '0;
         Win_Cnt   <= '0;
      end else if (clr) begin
         Stall_Cnt <= '0;
         Win_Cnt   <= '0;
      end else begin
         if (state == StStream && !Pix_Valid) Stall_Cnt <= Stall_Cnt + CNT_W'(1);
         if (win) Win_Cnt <= Win_Cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: doc/conv3x3_s2_sched.md
Name: conv3x3_s2_sched

Overview:
- Frame-level scheduler for the 3x3 stride-2 convolution unit.
- Accepts a raster-order pixel stream and tracks the row and column position of each pixel.
- Pulses Out_Valid on exactly the pixels that complete a stride-aligned 3x3 window.
- Sequences one frame per Start command; sits between the pixel source and the conv datapath / line buffers.

Parameters:
- IMG_W, 100, pixels per row (>= K).
- IMG_H, 100, rows per frame (>= K).
- K, 3, kernel size.
- STRIDE, 2, window stride (>= 1).
- CNT_W, 15, width of pixel, row and column counters (must hold IMG_W*IMG_H).

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle frame start request; sampled only in IDLE.
- Pix_Valid  in  1  source presents a pixel this cycle.
- Pix_Ready  out  1  scheduler accepts a pixel; high only in STREAM.
- Busy  out  1  high in STREAM and DONE.
- Line_Shift  out  1  1-cycle pulse when the last pixel of a row is accepted (advances line buffers).
- Out_Valid  out  1  1-cycle pulse: conv output for the current window is valid.
- Out_Row  out  CNT_W  output-map row index of the window; valid with Out_Valid.
- Out_Col  out  CNT_W  output-map column index of the window; valid with Out_Valid.
- Done  out  1  1-cycle pulse after the final window of a frame.

Behaviour:
- Reset (Rst=0, async): state=IDLE; all counters 0; Pix_Ready, Busy, Line_Shift, Out_Valid, Done = 0; Out_Row, Out_Col = 0.
- Accept: a pixel is accepted when Pix_Valid & Pix_Ready.
- Position counters: Col advances on each accepted pixel. At Col = IMG_W-1, Col wraps to 0 and Row increments.
- States:
  - IDLE: Pix_Ready=0. Start=1 -> STREAM; Row and Col cleared.
  - STREAM: Pix_Ready=1. Acceptance of pixel (IMG_H-1, IMG_W-1) -> DONE.
  - DONE: lasts one cycle; asserts Done; -> IDLE.
- Window condition, evaluated on the accepted pixel at (Row, Col):
  - Row >= K-1 and Col >= K-1;
  - (Row-(K-1)) mod STRIDE = 0;
  - (Col-(K-1)) mod STRIDE = 0.
- Latency: Out_Valid, Out_Row = (Row-(K-1))/STRIDE and Out_Col = (Col-(K-1))/STRIDE are registered and appear 1 cycle after acceptance.
- Division and mod: no divider. Use stride-phase counters that reset at K-1 and wrap at STRIDE-1, plus output-index counters that increment on phase 0.
- Output map size: OUT_W = (IMG_W-K)/STRIDE+1 and OUT_H = (IMG_H-K)/STRIDE+1 (integer division); 49x49 at defaults. Trailing rows/columns that do not fit a stride-aligned window produce no output.
- Line_Shift: registered, same 1-cycle latency as Out_Valid.
- Done: asserted in the cycle after the last pixel's Out_Valid/Line_Shift, i.e. 2 cycles after the last accept.
- Back-pressure from source: Pix_Valid=0 freezes all counters; no outputs pulse.
- Start while not IDLE: ignored.
- Reset mid-frame: immediate abort to IDLE; no Done pulse.
- Out_Row/Out_Col: hold their last values between pulses.

Optional Feature:
- CONV_SCHED_STAT_EN defined:
  - Adds output Stall_Cnt [CNT_W-1:0]: number of STREAM cycles with Pix_Valid=0 in the current frame.
  - Adds output Win_Cnt [CNT_W-1:0]: number of Out_Valid pulses in the current frame.
  - Both clear on the IDLE->STREAM transition, hold after Done, and reset to 0.
- Not defined: ports and logic absent; functional behaviour otherwise identical.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE=2'd0, STREAM=2'd1, DONE=2'd2);
  - default IMG_W, IMG_H, K, STRIDE, CNT_W;
  - derived OUT_W/OUT_H macros.
- One sub-module, conv_axis_cnt: a single-axis counter (position, stride phase, output index, wrap flag), instantiated twice — once for columns, once for rows enabled by the column wrap.

Test Plan:
- IMG_W=7, IMG_H=5, continuous Pix_Valid:
  - exactly 6 Out_Valid pulses, at (Out_Row, Out_Col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2);
  - first pulse 1 cycle after accept of pixel index 16 (row 2, col 2);
  - Done 2 cycles after the 35th accept.
- Same frame with Pix_Valid deasserted every other cycle: identical pulse sequence and indices; with CONV_SCHED_STAT_EN, Stall_Cnt=34 and Win_Cnt=6 after Done.
- Line_Shift check: 5 pulses per frame, each 1 cycle after accepts of pixel indices 6, 13, 20, 27, 34.
- Rst=0 asserted after 20 accepts: all outputs 0 immediately; no Done; the next Start gives a full correct frame.
- Start pulsed during STREAM: no effect on counters or pulse count; Start held during DONE: ignored, state returns to IDLE.
- Default 100x100: 2401 Out_Valid pulses, last at (48,48) after accept of pixel index 9898; no pulses for row 99 or column 99.
